chacha20_mem_xor_dma: RTL and testbench

In-place XOR engine between the ChaCha20 keystream core and the 32 Kword on-chip data memory. Software loads plaintext into the data memory, programs a base address and word count, and pulses `start`. The block reads each word over the memory's Avalon slave port, XORs it with one keystream word from the core, and writes the result back to the same address. It pulses `done` when the run completes.

---
 rtl/chacha20_mem_xor_dma_pkg.sv | 18 +
 rtl/chacha20_mem_xor_dma_if.sv | 33 +++
 rtl/chacha20_mem_xor_dma_be_gen.sv | 19 +
 rtl/chacha20_mem_xor_dma.sv | 160 ++++++++++++++++
 tb/tb_chacha20_mem_xor_dma.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha20_mem_xor_dma_pkg.sv
// Shared types and constants for the ChaCha20 in-place XOR DMA engine.
package chacha20_dma_pkg;

  localparam int DMA_ADDR_W = 15;
  localparam int DMA_DATA_W = 32;
  localparam int MEM_DEPTH  = 2 ** DMA_ADDR_W;
  localparam int BYTE_LANES = DMA_DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_KS,
    S_WR,
    S_DONE
  } state_e;

endpackage

// File: rtl/chacha20_mem_xor_dma_if.sv
// Engine-side bus bundle: Avalon data-memory port plus the keystream stream.
interface chacha20_mem_xor_dma_if
  import chacha20_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) ();

  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic                mem_debugaccess;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;
  logic                mem_clken;
  logic [DATA_W-1:0]   ks_data;
  logic                ks_valid;
  logic                ks_ready;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_debugaccess,
           mem_byteenable, mem_writedata, mem_clken, ks_ready,
    input  mem_readdata, ks_data, ks_valid
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_debugaccess,
           mem_byteenable, mem_writedata, mem_clken, ks_ready,
    output mem_readdata, ks_data, ks_valid
  );

endinterface

// File: rtl/chacha20_mem_xor_dma_be_gen.sv
// Byteenable generator for partial final words; only used with CHACHA_XOR_DMA_TAIL_EN.
module chacha20_dma_be_gen #(
  parameter int LANES = 4
) (
  input  logic             last_word_i,
  input  logic [1:0]       tail_bytes_i,
  output logic [LANES-1:0] be_o
);

  always_comb begin
    be_o = '1;
    if (last_word_i && (tail_bytes_i != 2'd0)) begin
      for (int i = 0; i < LANES; i++) begin
        if (i >= int'(tail_bytes_i)) be_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/chacha20_mem_xor_dma.sv
// In-place keystream XOR over the data memory: RD -> CAP -> KS -> WR per word.
// Optional tail byte masking on the last word: define CHACHA_XOR_DMA_TAIL_EN.
module chacha20_mem_xor_dma
  import chacha20_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       num_words_i,
`ifdef CHACHA_XOR_DMA_TAIL_EN
  input  logic [1:0]        tail_bytes_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  chacha20_mem_xor_dma_if.master bus
);

  localparam int LANES = DATA_W / 8;
  localparam int SUM_W = ADDR_W + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] pt_q, pt_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              err_q, err_d;
  logic [LANES-1:0]  be_w;
  logic [SUM_W-1:0]  end_sum;
  logic              ovf;

  // One bit wider than the count so base+count never wraps before the compare.
  assign end_sum = {2'b00, base_addr_i} + {{(SUM_W-16){1'b0}}, num_words_i};
  assign ovf     = end_sum > SUM_W'(MEM_DEPTH);

`ifdef CHACHA_XOR_DMA_TAIL_EN
  logic [1:0] tail_q, tail_d;

  chacha20_dma_be_gen #(.LANES(LANES)) u_be_gen (
    .last_word_i  (cnt_q == 16'd1),
    .tail_bytes_i (tail_q),
    .be_o         (be_w)
  );
`else
  assign be_w = '1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
`ifdef CHACHA_XOR_DMA_TAIL_EN
      tail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
`ifdef CHACHA_XOR_DMA_TAIL_EN
      tail_q  <= tail_d;
`endif
    end
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    cnt_d               = cnt_q;
    pt_d                = pt_q;
    wd_d                = wd_q;
    err_d               = err_q;
`ifdef CHACHA_XOR_DMA_TAIL_EN
    tail_d              = tail_q;
`endif
    busy_o              = (state_q != S_IDLE);
    done_o              = 1'b0;
    err_o               = 1'b0;
    bus.mem_address     = '0;
    bus.mem_chipselect  = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_debugaccess = 1'b0;
    bus.mem_byteenable  = '0;
    bus.mem_writedata   = '0;
    bus.mem_clken       = ~reset_i;
    bus.ks_ready        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i;
          cnt_d  = num_words_i;
          err_d  = (num_words_i != 16'd0) && ovf;
`ifdef CHACHA_XOR_DMA_TAIL_EN
          tail_d = tail_bytes_i;
`endif
          state_d = ((num_words_i == 16'd0) || ovf) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        bus.mem_address    = addr_q;
        bus.mem_chipselect = 1'b1;
        state_d            = S_CAP;
      end
      S_CAP: begin
        pt_d    = bus.mem_readdata;
        state_d = S_KS;
      end
      S_KS: begin
        bus.ks_ready = 1'b1;
        if (bus.ks_valid) begin
          wd_d    = pt_q ^ bus.ks_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        bus.mem_address     = addr_q;
        bus.mem_chipselect  = 1'b1;
        bus.mem_write       = 1'b1;
        bus.mem_debugaccess = 1'b1;
        bus.mem_byteenable  = be_w;
        bus.mem_writedata   = wd_q;
        addr_d              = addr_q + 1'b1;
        cnt_d               = cnt_q - 1'b1;
        state_d             = (cnt_q == 16'd1) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset must kill a write or keystream handshake already decoded this cycle.
    if (reset_i) begin
      busy_o              = 1'b0;
      done_o              = 1'b0;
      err_o               = 1'b0;
      bus.mem_address     = '0;
      bus.mem_chipselect  = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_debugaccess = 1'b0;
      bus.mem_byteenable  = '0;
      bus.mem_writedata   = '0;
      bus.ks_ready        = 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha20_mem_xor_dma.sv
// Directed bench: memory + keystream models, a vector table of runs, and hand sequences for stall/reset/tail.
module tb_chacha20_mem_xor_dma;
  import chacha20_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base;
  logic [15:0] num;
  logic [1:0]  tail;
  logic        busy, done, err;

  chacha20_mem_xor_dma_if bus ();

  always #5 clk = ~clk;

  chacha20_mem_xor_dma dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .base_addr_i  (base),
    .num_words_i  (num),
`ifdef CHACHA_XOR_DMA_TAIL_EN
    .tail_bytes_i (tail),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .bus          (bus)
  );

  logic [31:0] mem [0:32767];
  logic [31:0] ks_arr [0:63];
  logic        ks_v;
  int          ks_idx = 0;
  int          cs_cnt = 0;
  int          rdy_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  last_be = '0;
  logic [14:0] last_waddr = '0;
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign bus.ks_data  = ks_arr[ks_idx[5:0]];
  assign bus.ks_valid = ks_v;

  // Data memory (1-cycle read latency) plus bus activity counters.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write && bus.mem_debugaccess) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_byteenable[i])
            mem[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
        wr_cnt     <= wr_cnt + 1;
        last_be    <= bus.mem_byteenable;
        last_waddr <= bus.mem_address;
      end else begin
        bus.mem_readdata <= mem[bus.mem_address];
      end
    end
    if (bus.mem_chipselect) cs_cnt <= cs_cnt + 1;
    if (bus.ks_ready) rdy_cnt <= rdy_cnt + 1;
    if (bus.ks_valid && bus.ks_ready) ks_idx <= ks_idx + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Pulse start, return inclusive cycle count from start cycle to done cycle.
  task automatic run(input logic [14:0] b, input logic [15:0] n, input logic [1:0] t,
                     output int lat, output logic e);
    @(negedge clk);
    start = 1'b1; base = b; num = n; tail = t;
    lat = 0; e = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
      end
      if (done) begin
        lat = k + 1;
        e   = err;
        break;
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL done_timeout actual=none required=done");
    end
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  typedef struct packed {
    logic [14:0]      b;
    logic [15:0]      n;
    logic [2:0][31:0] pt;
    logic [2:0][31:0] ks;
    logic [2:0][31:0] exp;
    logic             e;
    logic [7:0]       lat;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    int lat, ks0, cs0, rdy0, wr0, nw;
    logic e;

    vecs[0] = '{b: 15'h0010, n: 16'd3,
                pt:  {32'h33333333, 32'h22222222, 32'h11111111},
                ks:  {32'h00000000, 32'h0F0F0F0F, 32'hFFFFFFFF},
                exp: {32'h33333333, 32'h2D2D2D2D, 32'hEEEEEEEE}, e: 1'b0, lat: 8'd14};
    vecs[1] = '{b: 15'h0020, n: 16'd0,
                pt:  {32'h0A0A0A0A, 32'h09090909, 32'h08080808},
                ks:  {32'h1, 32'h2, 32'h3},
                exp: {32'h0A0A0A0A, 32'h09090909, 32'h08080808}, e: 1'b0, lat: 8'd2};
    vecs[2] = '{b: 15'h7FFF, n: 16'd2,
                pt:  {32'h0, 32'h0, 32'hC3C3C3C3},
                ks:  {32'h1, 32'h2, 32'h3},
                exp: {32'h0, 32'h0, 32'hC3C3C3C3}, e: 1'b1, lat: 8'd2};
    vecs[3] = '{b: 15'h7FFF, n: 16'd1,
                pt:  {32'h0, 32'h0, 32'hA5A5A5A5},
                ks:  {32'h0, 32'h0, 32'h5A5A0000},
                exp: {32'h0, 32'h0, 32'hFFFFA5A5}, e: 1'b0, lat: 8'd6};
    vecs[4] = '{b: 15'h0100, n: 16'd2,
                pt:  {32'h77777777, 32'hDEADBEEF, 32'h12345678},
                ks:  {32'h0, 32'hFFFF0000, 32'h12345678},
                exp: {32'h77777777, 32'h2152BEEF, 32'h00000000}, e: 1'b0, lat: 8'd10};

    reset = 1'b1; start = 1'b0; base = '0; num = '0; tail = '0; ks_v = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_cs",    {31'd0, bus.mem_chipselect}, 32'd0);
    chk("rst_wr",    {31'd0, bus.mem_write}, 32'd0);
    chk("rst_dbg",   {31'd0, bus.mem_debugaccess}, 32'd0);
    chk("rst_rdy",   {31'd0, bus.ks_ready}, 32'd0);
    chk("rst_clken", {31'd0, bus.mem_clken}, 32'd0);
    chk("rst_addr",  {17'd0, bus.mem_address}, 32'd0);
    chk("rst_be",    {28'd0, bus.mem_byteenable}, 32'd0);
    chk("rst_wdata", bus.mem_writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("clken_up", {31'd0, bus.mem_clken}, 32'd1);
    chk("idle_rdy", {31'd0, bus.ks_ready}, 32'd0);

    // Table of runs
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 3; i++)
        if (int'(vecs[v].b) + i <= 32'h7FFF) preload(vecs[v].b + 15'(i), vecs[v].pt[i]);
      for (int i = 0; i < 3; i++) ks_arr[(ks_idx + i) % 64] = vecs[v].ks[i];
      ks0 = ks_idx; cs0 = cs_cnt; rdy0 = rdy_cnt; wr0 = wr_cnt;
      run(vecs[v].b, vecs[v].n, 2'd0, lat, e);
      chk($sformatf("v%0d_lat", v), lat, {24'd0, vecs[v].lat});
      chk($sformatf("v%0d_err", v), {31'd0, e}, {31'd0, vecs[v].e});
      nw = vecs[v].e ? 0 : int'(vecs[v].n);
      chk($sformatf("v%0d_ks_used", v), ks_idx - ks0, nw);
      chk($sformatf("v%0d_strobes", v), cs_cnt - cs0, 2 * nw);
      chk($sformatf("v%0d_writes", v), wr_cnt - wr0, nw);
      if (nw == 0) chk($sformatf("v%0d_rdy_cycles", v), rdy_cnt - rdy0, 0);
      else begin
        chk($sformatf("v%0d_last_be", v), {28'd0, last_be}, 32'hF);
        chk($sformatf("v%0d_last_addr", v), {17'd0, last_waddr},
            {17'd0, vecs[v].b + 15'(nw - 1)});
      end
      for (int i = 0; i < 3; i++)
        if (int'(vecs[v].b) + i <= 32'h7FFF)
          chk($sformatf("v%0d_mem%0d", v, i), mem[vecs[v].b + 15'(i)], vecs[v].exp[i]);
    end

    // Keystream stall in KS of word 2
    for (int i = 0; i < 3; i++) preload(15'h0010 + 15'(i), vecs[0].pt[i]);
    for (int i = 0; i < 3; i++) ks_arr[(ks_idx + i) % 64] = vecs[0].ks[i];
    ks0 = ks_idx;
    fork
      run(15'h0010, 16'd3, 2'd0, lat, e);
      begin
        int w;
        w = 0;
        while (ks_idx != ks0 + 1 && w < 100) begin @(negedge clk); w++; end
        ks_v = 1'b0;
        w = 0;
        while (!bus.ks_ready && w < 100) begin @(negedge clk); w++; end
        for (int s = 0; s < 5; s++) begin
          if (s != 0) @(negedge clk);
          chk("stall_rdy", {31'd0, bus.ks_ready}, 32'd1);
          chk("stall_cs", {31'd0, bus.mem_chipselect}, 32'd0);
        end
        @(negedge clk);
        ks_v = 1'b1;
      end
    join
    chk("stall_lat", lat, 19);
    chk("stall_err", {31'd0, e}, 32'd0);
    chk("stall_ks_used", ks_idx - ks0, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("stall_mem%0d", i), mem[15'h0010 + 15'(i)], vecs[0].exp[i]);

    // Reset during the first WR of a 4-word run
    for (int i = 0; i < 4; i++) preload(15'h0200 + 15'(i), 32'hCAFE0000 + i);
    for (int i = 0; i < 4; i++) ks_arr[(ks_idx + i) % 64] = 32'hFFFFFFFF;
    ks0 = ks_idx; wr0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; base = 15'h0200; num = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !bus.mem_write; k++) @(negedge clk);
    chk("pre_rst_in_wr", {31'd0, bus.mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr_gated", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_cs_gated", {31'd0, bus.mem_chipselect}, 32'd0);
    @(negedge clk);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_cs", {31'd0, bus.mem_chipselect}, 32'd0);
    chk("rst2_rdy", {31'd0, bus.ks_ready}, 32'd0);
    chk("rst2_addr", {17'd0, bus.mem_address}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst2_idle_busy", {31'd0, busy}, 32'd0);
    chk("rst2_idle_cs", {31'd0, bus.mem_chipselect}, 32'd0);
    chk("rst2_writes", wr_cnt - wr0, 0);
    chk("rst2_ks_used", ks_idx - ks0, 1);
    chk("rst2_mem_kept", mem[15'h0200], 32'hCAFE0000);
    ks_arr[ks_idx % 64] = 32'h0000FFFF;
    run(15'h0200, 16'd1, 2'd0, lat, e);
    chk("rst2_restart_lat", lat, 6);
    chk("rst2_restart_mem", mem[15'h0200], 32'hCAFEFFFF);
    chk("rst2_next_untouched", mem[15'h0201], 32'hCAFE0001);

`ifdef CHACHA_XOR_DMA_TAIL_EN
    preload(15'h0300, 32'h11223344);
    preload(15'h0301, 32'h55667788);
    ks_arr[ks_idx % 64]       = 32'hFFFFFFFF;
    ks_arr[(ks_idx + 1) % 64] = 32'hFFFFFFFF;
    run(15'h0300, 16'd2, 2'd2, lat, e);
    chk("tail_last_be", {28'd0, last_be}, 32'h3);
    chk("tail_mem0", mem[15'h0300], 32'hEEDDCCBB);
    chk("tail_mem1", mem[15'h0301], 32'h55668877);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
